// File: rtl/imem_boot_pkg.sv
// Shared constants for the instruction-memory boot loader: FSM state codes
// and word geometry.
package imem_boot_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned STATE_W    = 3;

  localparam logic [STATE_W-1:0] StIdle  = 3'd0;
  localparam logic [STATE_W-1:0] StHdr   = 3'd1;
  localparam logic [STATE_W-1:0] StLoad  = 3'd2;
  localparam logic [STATE_W-1:0] StWrite = 3'd3;
  localparam logic [STATE_W-1:0] StDone  = 3'd4;
  localparam logic [STATE_W-1:0] StErr   = 3'd5;

  // Number of whole words that fit in an instruction memory of mem_bytes bytes.
  function automatic int unsigned max_words(input int unsigned mem_bytes);
    return mem_bytes / WORD_BYTES;
  endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Big-endian byte-to-word packer: each accepted byte shifts in at [7:0], so the
// first of four bytes ends up in [31:24]. Shared by header and data words.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (shift_en) begin
      word_q <= {word_q[23:0], byte_in};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  assign word_out  = word_q;
  // Combinational so the owner can act on the 4th byte in the same cycle.
  assign word_full = shift_en && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Length-prefixed byte-serial loader that fills instruction memory word by word
// and holds the processor until the image is complete.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-2:0] words_loaded
);

  localparam int unsigned WL_W  = ADDR_W - 1;
  localparam int unsigned MAX_W = max_words(MEM_BYTES);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WL_W-1:0]    n_q, n_d;
  logic [WL_W-1:0]    wl_q, wl_d;
  logic [WL_W-1:0]    wl_inc;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;

  logic        ready_raw;
  logic        accept;
  logic        packer_clear;
  logic [31:0] word_out;
  logic        word_full;
  logic [31:0] hdr_word;

  byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (packer_clear),
    .shift_en (accept),
    .byte_in  (in_byte),
    .word_out (word_out),
    .word_full(word_full)
  );

  // Never advertise ready while reset is asserted; a byte taken then would be lost.
  assign in_ready = ready_raw && !reset;
  assign accept   = in_valid && in_ready;
  assign hdr_word = {word_out[23:0], in_byte};
  assign wl_inc   = wl_q + WL_W'(1);

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    wl_d         = wl_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    packer_clear = 1'b0;
    ready_raw    = 1'b0;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d      = StHdr;
          wl_d         = '0;
          packer_clear = 1'b1;
        end
      end
      StHdr: begin
        ready_raw = 1'b1;
        if (word_full) begin
          if (hdr_word == 32'd0) begin
            state_d = StDone;
          end else if (hdr_word > 32'(MAX_W)) begin
            state_d = StErr;
          end else begin
            n_d     = hdr_word[WL_W-1:0];
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        ready_raw = 1'b1;
        if (word_full) begin
          state_d = StWrite;
          addr_d  = {wl_q[ADDR_W-3:0], 2'b00};
        end
      end
      StWrite: begin
        wdata_d = word_out;
        wl_d    = wl_inc;
        state_d = (wl_inc == n_q) ? StDone : StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      n_q     <= '0;
      wl_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wl_q    <= wl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Reset in the WRITE cycle must still suppress the strobe.
  assign mem_we       = (state_q == StWrite) && !reset;
  assign mem_addr     = addr_q;
  assign mem_wdata    = (state_q == StWrite) ? word_out : wdata_q;
  assign cpu_hold     = (state_q != StDone);
  assign done         = (state_q == StDone);
  assign err          = (state_q == StErr);
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: hand-written timing sequences, a
// header table and randomized loads checked against a simple image model.
module tb_imem_boot_loader;

  localparam int unsigned MEM_BYTES = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned MAXW      = MEM_BYTES / 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W-2:0] words_loaded;

  imem_boot_loader #(
    .MEM_BYTES(MEM_BYTES),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_byte     (in_byte),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  typedef struct {
    logic [31:0] hdr;
    logic        exp_done;
    logic        exp_err;
    int          exp_words;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    logic acc;
    int   g;
    acc = 1'b0;
    g   = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (g) begin
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_byte  = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: got not-accepted expected accepted (byte %0h)", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    send_byte(w[31:24], gap_max);
    send_byte(w[23:16], gap_max);
    send_byte(w[15:8], gap_max);
    send_byte(w[7:0], gap_max);
  endtask

  // Reference outcome of a header: how many words the image carries.
  function automatic int ref_words(input logic [31:0] n);
    return (n >= 1 && n <= MAXW) ? int'(n) : 0;
  endfunction

  task automatic run_load(input string tag, input logic [31:0] hdr, input int gap,
                          input logic exp_done, input logic exp_err, input int exp_words);
    logic [31:0] img[$];
    int nw;
    nw = ref_words(hdr);
    for (int i = 0; i < nw; i++) img.push_back($urandom);
    clear_log();
    pulse_start();
    send_word(hdr, gap);
    for (int i = 0; i < nw; i++) send_word(img[i], gap);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_hold"}, cpu_hold, !exp_done);
    chk({tag, "_words"}, words_loaded, exp_words);
    chk({tag, "_ready"}, in_ready, 1'b0);
    chk({tag, "_nwrites"}, wa_q.size(), exp_words);
    for (int i = 0; i < wa_q.size() && i < nw; i++) begin
      chk({tag, "_addr"}, wa_q[i], 32'(i * 4));
      chk({tag, "_data"}, wd_q[i], img[i]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_words", words_loaded, 0);
    @(posedge clk);
    #1;

    // Two-word load with exact write timing and a byte held off during WRITE
    clear_log();
    pulse_start();
    send_word(32'h0000_0002, 0);
    send_word(32'h8C01_0004, 0);
    in_valid = 1'b1;
    in_byte  = 8'h00;
    @(negedge clk);
    chk("w0_we", mem_we, 1);
    chk("w0_addr", mem_addr, 0);
    chk("w0_data", mem_wdata, 32'h8C01_0004);
    chk("w0_ready_in_write", in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("w0_we_one_cycle", mem_we, 0);
    chk("w0_ready_after", in_ready, 1);
    chk("w0_words", words_loaded, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send_byte(8'h22, 0);
    send_byte(8'h18, 0);
    send_byte(8'h20, 0);
    @(negedge clk);
    chk("w1_we", mem_we, 1);
    chk("w1_addr", mem_addr, 4);
    chk("w1_data", mem_wdata, 32'h0022_1820);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("two_done", done, 1);
    chk("two_hold", cpu_hold, 0);
    chk("two_words", words_loaded, 2);
    chk("two_we_off", mem_we, 0);
    chk("two_addr_hold", mem_addr, 4);
    chk("two_data_hold", mem_wdata, 32'h0022_1820);
    @(posedge clk);
    #1;
    chk("two_nwrites", wa_q.size(), 2);

    // Zero-length image
    clear_log();
    pulse_start();
    send_word(32'h0, 0);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_hold", cpu_hold, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_nwrites", wa_q.size(), 0);

    // Oversize header, then start leaves ERR
    clear_log();
    pulse_start();
    send_word(32'h0000_0009, 0);
    @(negedge clk);
    chk("big_err", err, 1);
    chk("big_hold", cpu_hold, 1);
    chk("big_ready", in_ready, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("big_nwrites", wa_q.size(), 0);
    pulse_start();
    @(negedge clk);
    chk("big_restart_err", err, 0);
    chk("big_restart_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Reset mid-word discards the partial word
    clear_log();
    send_word(32'h0000_0002, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_ready", in_ready, 0);
    chk("mid_we", mem_we, 0);
    chk("mid_addr", mem_addr, 0);
    chk("mid_wdata", mem_wdata, 0);
    chk("mid_hold", cpu_hold, 1);
    chk("mid_words", words_loaded, 0);
    @(posedge clk);
    #1;
    chk("mid_nwrites", wa_q.size(), 0);
    pulse_start();
    send_word(32'h0000_0001, 0);
    send_word(32'hA5A5_1234, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_reload_n", wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      chk("mid_reload_addr", wa_q[0], 0);
      chk("mid_reload_data", wd_q[0], 32'hA5A5_1234);
    end
    chk("mid_reload_done", done, 1);

    // Reset coinciding with WRITE suppresses the strobe
    clear_log();
    pulse_start();
    send_word(32'h0000_0001, 0);
    send_word(32'hDEAD_BEEF, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_we", mem_we, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstw_done", done, 0);
    chk("rstw_hold", cpu_hold, 1);
    @(posedge clk);
    #1;
    chk("rstw_nwrites", wa_q.size(), 0);

    // start during LOAD is ignored; start in DONE reloads
    clear_log();
    pulse_start();
    send_word(32'h0000_0001, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    pulse_start();
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("ign_nwrites", wa_q.size(), 1);
    if (wa_q.size() == 1) chk("ign_data", wd_q[0], 32'h1234_5678);
    chk("ign_done", done, 1);
    clear_log();
    pulse_start();
    @(negedge clk);
    chk("re_hold", cpu_hold, 1);
    chk("re_done", done, 0);
    chk("re_words", words_loaded, 0);
    @(posedge clk);
    #1;
    send_word(32'h0000_0001, 0);
    send_word(32'hCAFE_F00D, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("re_nwrites", wa_q.size(), 1);
    if (wa_q.size() == 1) begin
      chk("re_addr", wa_q[0], 0);
      chk("re_data", wd_q[0], 32'hCAFE_F00D);
    end

    // Header table with random data and random bubbles
    tbl[0] = '{hdr: 32'd0,         exp_done: 1'b1, exp_err: 1'b0, exp_words: 0};
    tbl[1] = '{hdr: 32'd1,         exp_done: 1'b1, exp_err: 1'b0, exp_words: 1};
    tbl[2] = '{hdr: 32'd2,         exp_done: 1'b1, exp_err: 1'b0, exp_words: 2};
    tbl[3] = '{hdr: 32'd7,         exp_done: 1'b1, exp_err: 1'b0, exp_words: 7};
    tbl[4] = '{hdr: 32'd8,         exp_done: 1'b1, exp_err: 1'b0, exp_words: 8};
    tbl[5] = '{hdr: 32'd9,         exp_done: 1'b0, exp_err: 1'b1, exp_words: 0};
    tbl[6] = '{hdr: 32'h0000_0108, exp_done: 1'b0, exp_err: 1'b1, exp_words: 0};
    tbl[7] = '{hdr: 32'hFFFF_FFFF, exp_done: 1'b0, exp_err: 1'b1, exp_words: 0};
    for (int i = 0; i < 8; i++) begin
      run_load($sformatf("tbl%0d", i), tbl[i].hdr, 3, tbl[i].exp_done, tbl[i].exp_err,
               tbl[i].exp_words);
    end

    // Random headers: expectations come from the image model
    for (int i = 0; i < 12; i++) begin
      logic [31:0] n;
      n = 32'($urandom_range(0, 11));
      run_load($sformatf("rnd%0d", i), n, int'($urandom_range(0, 4)),
               (n <= MAXW), (n > MAXW), ref_words(n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
